clken_bank: RTL and testbench
=============================

Name: clken_bank

Overview:
- Parametrised bank of clock-enable generators for the board top level.
- Replaces the per-rate divider instances, the toggle registers and the hand-rolled 3-bit CPU clock divider.
- Provides NUM_CH independently programmable divide-by-N channels, each with a one-cycle pulse and a 50%-duty square output.
- Provides a CPU phase counter with free-run and single-step modes, all in the core clock domain.

Parameters:
- NUM_CH, 4, number of divider channels.
- CNT_W, 16, width of each channel counter and divisor.
- PH_W, 3, width of the CPU phase counter; the CPU clock is the phase MSB.
- STEP_INC, 4, phase increment applied per step event (half a CPU period when PH_W=3).

Ports:
- clock  in  1  core clock (33.33 MHz).
- reset  in  1  asynchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable.
- ch_div  in  NUM_CH*CNT_W  per-channel divisor; channel i occupies bits [i*CNT_W +: CNT_W].
- ch_pulse  out  NUM_CH  one-cycle pulse, once every ch_div cycles.
- ch_square  out  NUM_CH  toggles on every ch_pulse.
- step_enable  in  1  1 = single-step mode, 0 = free run; already debounced and synchronous.
- step  in  1  step request level; already debounced and synchronous.
- cpu_phase  out  PH_W  CPU phase counter.
- cpu_clk  out  1  cpu_phase MSB; drives a BUFG at the top level.
- cpu_tick  out  1  one-cycle pulse when cpu_phase wraps to zero.

Behaviour:
- Reset (asynchronous) clears every register:
  - channel counters, ch_pulse, ch_square, cpu_phase and the step-edge register all go to 0;
  - cpu_clk and cpu_tick go to 0.
- All outputs are registered. No combinational path from any input to any output.

Channel i, each cycle:
- If ch_en[i]=0 or ch_div[i]=0:
  - counter <= 0, ch_pulse <= 0;
  - ch_square holds its value.
- Else if counter >= ch_div[i]-1:
  - counter <= 0, ch_pulse <= 1, ch_square <= ~ch_square.
- Else:
  - counter <= counter+1, ch_pulse <= 0.

Channel rules:
- Pulse period is exactly ch_div cycles.
- After ch_en rises (counter at 0), the first pulse is registered ch_div cycles later.
- ch_div=1 gives ch_pulse high continuously and ch_square toggling every cycle.
- Lowering ch_div mid-count below the current count: the >= compare fires on the next cycle and the counter wraps. No runaway to 2^CNT_W.
- Raising ch_div mid-count: the counter simply continues to the new terminal value.

CPU phase:
- Internal step_q <= step every cycle. A step event is step & ~step_q.
- step_enable=0: cpu_phase <= cpu_phase + 1 (mod 2^PH_W). Step events are ignored.
- step_enable=1: on a step event, cpu_phase <= cpu_phase + STEP_INC (mod 2^PH_W); otherwise cpu_phase holds.
- cpu_clk = cpu_phase[PH_W-1], registered together with cpu_phase.
- cpu_tick is registered high for exactly the cycle in which cpu_phase holds 0 after a wrap, i.e. the new value's computed sum overflowed. It is not asserted in the reset state.
- Mode change: toggling step_enable takes effect on the next cycle. cpu_phase is never cleared by a mode change.
- step held high produces a single event. step already high on leaving reset produces no event, because step_q also resets to 0 but the first sampled cycle … rule: step_q is loaded with step on the first cycle after reset and no event is generated that cycle.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), with no trailing pulse.

Decomposition:
- Shared package clken_pkg: default CNT_W/PH_W constants, plus the canonical divisor constants DIV_1KHZ=33333 and DIV_200KHZ=166 used by the top level.
- Sub-module clken_channel (one counter, pulse and square), instantiated NUM_CH times via generate.
- The CPU phase logic lives in clken_bank itself.

Test Plan:
- Reset with ch_en=all 1, ch_div[0]=3 -> ch_pulse[0] at cycles 3, 6, 9 after reset release; ch_square[0] = 0→1→0→1 at those cycles.
- ch_div[1]=10, counter reaches 7, then ch_div[1] set to 4 -> pulse on the next cycle; subsequent pulses every 4 cycles.
- ch_div[2]=0 with ch_en=1, and ch_en[3]=0 with ch_div=5 -> both channels produce no pulse for 100 cycles; their ch_square values are unchanged.
- step_enable=0, PH_W=3 -> cpu_clk has period 8 (4 high, 4 low); cpu_tick exactly once per 8 cycles, on the cycle cpu_phase=0.
- step_enable=1, STEP_INC=4, step held high for 20 cycles then low, repeated 4 times -> cpu_phase = 4, 0, 4, 0; cpu_tick on the 2nd and 4th events only; cpu_phase static between events.
- Assert reset asynchronously mid-period (not on a clock edge) -> all outputs 0 within the same cycle; after release, channel 0 with ch_div=3 resumes its first pulse at cycle 3.

Source files
------------

// File: rtl/clken_pkg.sv
// Shared constants for the clock-enable bank: default widths, CPU phase
// mode encoding and the canonical board-level divisors.
package clken_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int PH_W_DEF  = 3;

  // Divisors from the 33.33 MHz core clock used by the board top level.
  localparam int DIV_1KHZ   = 33333;
  localparam int DIV_200KHZ = 166;

  typedef enum logic {
    PH_RUN  = 1'b0,
    PH_STEP = 1'b1
  } ph_mode_e;

endpackage

// File: rtl/clken_channel.sv
// One divide-by-N clock-enable channel: a single-cycle pulse every div cycles
// and a square output that toggles on each pulse.
module clken_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic             pulse,
  output logic             square
);

  logic [CNT_W-1:0] cnt;

  // The >= compare lets a divisor lowered below the running count wrap at once
  // instead of counting all the way round the counter width.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      pulse  <= 1'b0;
      square <= 1'b0;
    end else if (!en || div == '0) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (cnt >= div - CNT_W'(1)) begin
      cnt    <= '0;
      pulse  <= 1'b1;
      square <= ~square;
    end else begin
      cnt   <= cnt + CNT_W'(1);
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/clken_bank.sv
// Bank of NUM_CH programmable clock-enable channels plus the CPU phase counter
// with free-run and single-step modes, all on the core clock.
module clken_bank
  import clken_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PH_W     = PH_W_DEF,
  parameter int STEP_INC = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] ch_div,
  output logic [NUM_CH-1:0]       ch_pulse,
  output logic [NUM_CH-1:0]       ch_square,
  input  logic                    step_enable,
  input  logic                    step,
  output logic [PH_W-1:0]         cpu_phase,
  output logic                    cpu_clk,
  output logic                    cpu_tick
);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      clken_channel #(.CNT_W(CNT_W)) u_ch (
        .clock  (clock),
        .reset  (reset),
        .en     (ch_en[g]),
        .div    (ch_div[g*CNT_W +: CNT_W]),
        .pulse  (ch_pulse[g]),
        .square (ch_square[g])
      );
    end
  endgenerate

  ph_mode_e        mode;
  logic            step_q;
  logic            step_armed;
  logic            step_evt;
  logic [PH_W-1:0] phase_inc;
  logic [PH_W:0]   phase_sum;

  assign mode = ph_mode_e'(step_enable);

  // step_armed masks the first cycle out of reset so a step already held high
  // then only loads step_q and never counts as an edge.
  always_comb begin
    step_evt  = step & ~step_q & step_armed;
    phase_inc = '0;
    if (mode == PH_RUN)
      phase_inc = PH_W'(1);
    else if (step_evt)
      phase_inc = PH_W'(STEP_INC);
    phase_sum = {1'b0, cpu_phase} + {1'b0, phase_inc};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_q     <= 1'b0;
      step_armed <= 1'b0;
      cpu_phase  <= '0;
      cpu_clk    <= 1'b0;
      cpu_tick   <= 1'b0;
    end else begin
      step_q     <= step;
      step_armed <= 1'b1;
      cpu_phase  <= phase_sum[PH_W-1:0];
      cpu_clk    <= phase_sum[PH_W-1];
      cpu_tick   <= phase_sum[PH_W];
    end
  end

endmodule

// File: tb/tb_clken_bank.sv
// Scoreboard bench for clken_bank: a cycle model predicts every output,
// with directed checks on the key boundary cases.
module tb_clken_bank;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 16;
  localparam int PH_W     = 3;
  localparam int STEP_INC = 4;

  logic                    clock;
  logic                    reset;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*CNT_W-1:0] ch_div;
  logic [NUM_CH-1:0]       ch_pulse;
  logic [NUM_CH-1:0]       ch_square;
  logic                    step_enable;
  logic                    step;
  logic [PH_W-1:0]         cpu_phase;
  logic                    cpu_clk;
  logic                    cpu_tick;

  int div_arr [NUM_CH];

  clken_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PH_W(PH_W), .STEP_INC(STEP_INC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ch_en       (ch_en),
    .ch_div      (ch_div),
    .ch_pulse    (ch_pulse),
    .ch_square   (ch_square),
    .step_enable (step_enable),
    .step        (step),
    .cpu_phase   (cpu_phase),
    .cpu_clk     (cpu_clk),
    .cpu_tick    (cpu_tick)
  );

  initial clock = 1'b0;
  always #15 clock = ~clock;

  always_comb begin
    ch_div = '0;
    for (int i = 0; i < NUM_CH; i++)
      ch_div[i*CNT_W +: CNT_W] = 16'(div_arr[i]);
  end

  typedef struct packed {
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] sq;
    logic [PH_W-1:0]   phase;
    logic              cclk;
    logic              tick;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  int          m_cnt [NUM_CH];
  logic [3:0]  m_pulse, m_sq;
  int          m_phase;
  logic        m_stepq, m_armed, m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    m_pulse = '0;
    m_sq    = '0;
    m_phase = 0;
    m_stepq = 1'b0;
    m_armed = 1'b0;
    m_tick  = 1'b0;
  endtask

  task automatic model_step();
    int nxt;
    logic ev;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!ch_en[i] || div_arr[i] == 0) begin
        m_cnt[i]   = 0;
        m_pulse[i] = 1'b0;
      end else if (m_cnt[i] + 1 >= div_arr[i]) begin
        m_cnt[i]   = 0;
        m_pulse[i] = 1'b1;
        m_sq[i]    = ~m_sq[i];
      end else begin
        m_cnt[i]   = m_cnt[i] + 1;
        m_pulse[i] = 1'b0;
      end
    end
    ev = m_armed && step && !m_stepq;
    if (!step_enable) nxt = m_phase + 1;
    else if (ev)      nxt = m_phase + STEP_INC;
    else              nxt = m_phase;
    m_tick  = (nxt >= (1 << PH_W));
    m_phase = nxt % (1 << PH_W);
    m_stepq = step;
    m_armed = 1'b1;
  endtask

  // Predict, push, clock once, then pop and compare just after the edge.
  task automatic run_cycle();
    exp_t e;
    model_step();
    e.pulse = m_pulse;
    e.sq    = m_sq;
    e.phase = 3'(m_phase);
    e.cclk  = e.phase[PH_W-1];
    e.tick  = m_tick;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      chk("sb_pulse", 32'(ch_pulse),  32'(e.pulse));
      chk("sb_square", 32'(ch_square), 32'(e.sq));
      chk("sb_phase", 32'(cpu_phase), 32'(e.phase));
      chk("sb_cpu_clk", 32'(cpu_clk), 32'(e.cclk));
      chk("sb_cpu_tick", 32'(cpu_tick), 32'(e.tick));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulse"}, 32'(ch_pulse), 32'(0));
    chk({tag, "_square"}, 32'(ch_square), 32'(0));
    chk({tag, "_phase"}, 32'(cpu_phase), 32'(0));
    chk({tag, "_cpu_clk"}, 32'(cpu_clk), 32'(0));
    chk({tag, "_cpu_tick"}, 32'(cpu_tick), 32'(0));
  endtask

  int exp_ph [4] = '{4, 0, 4, 0};

  initial begin
    int ticks, clk_hi, p23, guard;
    reset       = 1'b1;
    ch_en       = 4'b0111;
    div_arr[0]  = 3;
    div_arr[1]  = 10;
    div_arr[2]  = 0;
    div_arr[3]  = 5;
    step_enable = 1'b0;
    step        = 1'b0;
    model_reset();
    #5;
    chk_all_zero("reset");

    @(negedge clock);
    reset = 1'b0;

    // ch0 divide-by-3 pulses; ch1 divisor lowered from 10 to 4 at count 7.
    for (int c = 1; c <= 12; c++) begin
      run_cycle();
      if (c % 3 == 0) begin
        chk("ch0_pulse", 32'(ch_pulse[0]), 32'(1));
        chk("ch0_square", 32'(ch_square[0]), 32'((c / 3) % 2));
      end
      if (c == 7) div_arr[1] = 4;
      if (c == 8 || c == 12) chk("ch1_shrink_pulse", 32'(ch_pulse[1]), 32'(1));
    end

    // Free run: 13 full CPU periods; ch2 (div 0) and ch3 (disabled) stay idle.
    ticks = 0; clk_hi = 0; p23 = 0;
    for (int c = 0; c < 104; c++) begin
      run_cycle();
      ticks  += int'(cpu_tick);
      clk_hi += int'(cpu_clk);
      p23    += int'(ch_pulse[2]) + int'(ch_pulse[3]);
    end
    chk("run_ticks", 32'(ticks), 32'(13));
    chk("run_clk_high", 32'(clk_hi), 32'(52));
    chk("idle_pulses", 32'(p23), 32'(0));
    chk("idle_square", 32'(ch_square[3:2]), 32'(0));

    guard = 0;
    while (m_phase != 0 && guard < 16) begin
      run_cycle();
      guard++;
    end
    chk("align_phase", 32'(cpu_phase), 32'(0));

    // Single-step: each long step-high produces one +4 event.
    step_enable = 1'b1;
    ticks = 0;
    for (int r = 0; r < 4; r++) begin
      step = 1'b1;
      for (int c = 0; c < 20; c++) begin
        run_cycle();
        ticks += int'(cpu_tick);
      end
      step = 1'b0;
      for (int c = 0; c < 20; c++) begin
        run_cycle();
        ticks += int'(cpu_tick);
      end
      chk("step_phase", 32'(cpu_phase), 32'(exp_ph[r]));
    end
    chk("step_ticks", 32'(ticks), 32'(2));

    // Back to free run, then an asynchronous reset between clock edges.
    step_enable = 1'b0;
    ch_en       = 4'b1111;
    for (int c = 0; c < 5; c++) run_cycle();
    #9;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    chk("sb_drained", 32'(sb.size()), 32'(0));
    ch_en = 4'b0001;
    step  = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      run_cycle();
      chk("post_reset_ch0", 32'(ch_pulse[0]), 32'((c % 3 == 0) ? 1 : 0));
    end
    chk("held_step_no_event", 32'(cpu_phase), 32'(6));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
